cmd_frame_parser: RTL and testbench

Consumer end of the command byte stream that the switch core delivers from the selected comm port (A or B). It pops bytes from the core's receive FIFO, hunts for and parses fixed 5-byte command frames, and validates each frame's checksum. Switch commands drive `force_swi`/`com_swi` back into the core. Every other valid frame is forwarded byte-by-byte to both CPU UART transmitters via `tf_push_cpuAB`/`tdr_cpuAB`, and checksum failures raise `error` (LED5).

---
 rtl/cmd_frame_pkg.sv | 33 +++
 rtl/cmd_byte_fetch.sv | 49 ++++
 rtl/cmd_frame_parser.sv | 184 ++++++++++++++++++
 tb/tb_cmd_frame_parser.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_frame_pkg.sv
// ---------------------------------------------------------------------------
// cmd_frame_pkg
// Shared definitions for the command frame parser.
//   - state_e     : parser FSM states
//   - SYNC1/SYNC2 : frame header bytes
//   - CMD_SW_A/B  : switch-to-CPU-A / switch-to-CPU-B command codes
//   - FRAME_LEN   : bytes per frame (SYNC1, SYNC2, CMD, ARG, CHK)
//   - frame_chk() : frame checksum, (CMD + ARG) mod 256
// ---------------------------------------------------------------------------
package cmd_frame_pkg;

  localparam logic [7:0] SYNC1    = 8'hEB;
  localparam logic [7:0] SYNC2    = 8'h90;
  localparam logic [7:0] CMD_SW_A = 8'h5A;
  localparam logic [7:0] CMD_SW_B = 8'hA5;
  localparam int         FRAME_LEN = 5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR2 = 3'd1,
    CMD  = 3'd2,
    ARG  = 3'd3,
    CHK  = 3'd4,
    EXEC = 3'd5,
    FWD  = 3'd6
  } state_e;

  // 8-bit addition wraps naturally, giving the mod-256 checksum.
  function automatic logic [7:0] frame_chk(input logic [7:0] cmd_b, input logic [7:0] arg_b);
    return cmd_b + arg_b;
  endfunction

endpackage

// File: rtl/cmd_byte_fetch.sv
// ---------------------------------------------------------------------------
// cmd_byte_fetch
// Pops bytes from the selected receive FIFO with a mandatory one-cycle gap
// after every pop so the FIFO's count and head byte can settle.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   com_count    : bytes pending in the FIFO
//   rec_command  : FIFO head byte
//   hold         : stall request from the parser (EXEC/FWD)
//   com_pop      : one-cycle pop strobe (same cycle the byte is taken)
//   byte_valid   : a byte is taken this cycle; the parser registers it at
//                  the end of the cycle, so it acts on it from the next one
//   byte_data    : the byte being taken
// ---------------------------------------------------------------------------
module cmd_byte_fetch #(
  parameter int FIFO_CNT_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FIFO_CNT_W-1:0] com_count,
  input  logic [7:0]            rec_command,
  input  logic                  hold,
  output logic                  com_pop,
  output logic                  byte_valid,
  output logic [7:0]            byte_data
);

  logic gap_q, gap_d;
  logic pop;

  always_comb begin
    pop   = !gap_q && !hold && (com_count != '0);
    // The cycle after a pop is always idle.
    gap_d = pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q <= 1'b0;
    end else begin
      gap_q <= gap_d;
    end
  end

  assign com_pop    = pop;
  assign byte_valid = pop;
  assign byte_data  = rec_command;

endmodule

// File: rtl/cmd_frame_parser.sv
// ---------------------------------------------------------------------------
// cmd_frame_parser
// Hunts for 5-byte command frames (SYNC1 SYNC2 CMD ARG CHK) in the selected
// receive FIFO, validates CHK = CMD + ARG, executes switch commands and
// forwards every other valid frame to the CPU A/B UART transmitters.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   com_count           : bytes pending in the receive FIFO
//   rec_command         : receive FIFO head byte
//   command_time_out_d  : idle timeout; aborts a partially received frame
//   com_pop             : one-cycle FIFO pop strobe
//   force_swi           : one-cycle CPU switch pulse
//   com_swi             : commanded CPU (0 = A, 1 = B), level
//   error               : checksum error flag, level
//   tf_push_cpuAB       : push strobe to the CPU TX FIFOs
//   tdr_cpuAB           : byte pushed to the CPU TX FIFOs
// ---------------------------------------------------------------------------
module cmd_frame_parser
  import cmd_frame_pkg::*;
#(
  parameter int FIFO_CNT_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FIFO_CNT_W-1:0] com_count,
  input  logic [7:0]            rec_command,
  input  logic                  command_time_out_d,
  output logic                  com_pop,
  output logic                  force_swi,
  output logic                  com_swi,
  output logic                  error,
  output logic                  tf_push_cpuAB,
  output logic [7:0]            tdr_cpuAB
);

  state_e     state_q, state_d;
  logic [7:0] buf_q [FRAME_LEN];
  logic [7:0] buf_d [FRAME_LEN];
  logic [2:0] fwd_idx_q, fwd_idx_d;
  logic       force_swi_q, force_swi_d;
  logic       com_swi_q, com_swi_d;
  logic       error_q, error_d;

  logic       hold;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       in_frame;

  assign hold = (state_q == EXEC) || (state_q == FWD);

  cmd_byte_fetch #(
    .FIFO_CNT_W (FIFO_CNT_W)
  ) u_fetch (
    .clk         (clk),
    .rst_n       (rst_n),
    .com_count   (com_count),
    .rec_command (rec_command),
    .hold        (hold),
    .com_pop     (com_pop),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data)
  );

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    fwd_idx_d   = fwd_idx_q;
    force_swi_d = 1'b0;
    com_swi_d   = com_swi_q;
    error_d     = error_q;
    in_frame    = (state_q == HDR2) || (state_q == CMD) ||
                  (state_q == ARG)  || (state_q == CHK);

    // Timeout beats any byte taken in the same cycle; that byte is dropped.
    if (in_frame && command_time_out_d) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (byte_valid && byte_data == SYNC1) begin
            buf_d[0] = byte_data;
            state_d  = HDR2;
          end
        end
        HDR2: begin
          if (byte_valid) begin
            if (byte_data == SYNC2) begin
              buf_d[1] = byte_data;
              state_d  = CMD;
            end else if (byte_data != SYNC1) begin
              state_d  = IDLE;
            end
            // A repeated SYNC1 keeps us waiting for SYNC2.
          end
        end
        CMD: begin
          if (byte_valid) begin
            buf_d[2] = byte_data;
            state_d  = ARG;
          end
        end
        ARG: begin
          if (byte_valid) begin
            buf_d[3] = byte_data;
            state_d  = CHK;
          end
        end
        CHK: begin
          if (byte_valid) begin
            buf_d[4] = byte_data;
            state_d  = EXEC;
          end
        end
        EXEC: begin
          if (frame_chk(buf_q[2], buf_q[3]) != buf_q[4]) begin
            error_d = 1'b1;
            state_d = IDLE;
          end else begin
            error_d = 1'b0;
            if (buf_q[2] == CMD_SW_A) begin
              force_swi_d = 1'b1;
              com_swi_d   = 1'b0;
              state_d     = IDLE;
            end else if (buf_q[2] == CMD_SW_B) begin
              force_swi_d = 1'b1;
              com_swi_d   = 1'b1;
              state_d     = IDLE;
            end else begin
              fwd_idx_d = 3'd0;
              state_d   = FWD;
            end
          end
        end
        FWD: begin
          if (fwd_idx_q == 3'(FRAME_LEN - 1)) begin
            fwd_idx_d = 3'd0;
            state_d   = IDLE;
          end else begin
            fwd_idx_d = fwd_idx_q + 3'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fwd_idx_q   <= 3'd0;
      force_swi_q <= 1'b0;
      com_swi_q   <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      fwd_idx_q   <= fwd_idx_d;
      force_swi_q <= force_swi_d;
      com_swi_q   <= com_swi_d;
      error_q     <= error_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < FRAME_LEN; gi++) begin : g_buf
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          buf_q[gi] <= 8'h00;
        end else begin
          buf_q[gi] <= buf_d[gi];
        end
      end
    end
  endgenerate

  // Pushes are decoded straight from the state so a reset during FWD
  // cuts them off in the same cycle.
  assign tf_push_cpuAB = (state_q == FWD);
  assign tdr_cpuAB     = (state_q == FWD) ? buf_q[fwd_idx_q] : 8'h00;
  assign force_swi     = force_swi_q;
  assign com_swi       = com_swi_q;
  assign error         = error_q;

endmodule

// File: tb/tb_cmd_frame_parser.sv
module tb_cmd_frame_parser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] com_count = 5'd0;
  logic [7:0] rec_command = 8'h00;
  logic       command_time_out_d = 1'b0;
  logic       com_pop;
  logic       force_swi;
  logic       com_swi;
  logic       error;
  logic       tf_push_cpuAB;
  logic [7:0] tdr_cpuAB;

  cmd_frame_parser #(.FIFO_CNT_W(5)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .com_count          (com_count),
    .rec_command        (rec_command),
    .command_time_out_d (command_time_out_d),
    .com_pop            (com_pop),
    .force_swi          (force_swi),
    .com_swi            (com_swi),
    .error              (error),
    .tf_push_cpuAB      (tf_push_cpuAB),
    .tdr_cpuAB          (tdr_cpuAB)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    bit         first;
  } push_exp_t;

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         last_pop = -100;
  int         last_push = -100;
  bit         prev_force = 1'b0;
  logic [7:0] fifo[$];
  push_exp_t  exp_push[$];
  bit         exp_sw[$];
  int         pop_cyc[$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end else begin
      $display("[TB] ok   %s: %0h", name, act);
    end
  endfunction

  // Receive FIFO model: pops on com_pop, presents count/head after the edge.
  always @(posedge clk) begin
    if (com_pop && fifo.size() != 0) void'(fifo.pop_front());
    com_count   <= (fifo.size() > 31) ? 5'd31 : 5'(fifo.size());
    rec_command <= (fifo.size() != 0) ? fifo[0] : 8'h00;
  end

  // Monitor / scoreboard: samples on the falling edge.
  always @(negedge clk) begin
    push_exp_t e;
    cyc++;
    if (rst_n) begin
      if (tf_push_cpuAB) begin
        if (exp_push.size() == 0) begin
          check("unexpected_push", 32'(tf_push_cpuAB), 32'd0);
        end else begin
          e = exp_push.pop_front();
          check("push_data", 32'(tdr_cpuAB), 32'(e.data));
          if (e.first) check("push_latency", 32'(cyc - last_pop), 32'd2);
          else         check("push_consecutive", 32'(cyc - last_push), 32'd1);
        end
        last_push = cyc;
      end
      if (force_swi) begin
        if (exp_sw.size() == 0) check("unexpected_force_swi", 32'(force_swi), 32'd0);
        else                    check("com_swi_at_pulse", 32'(com_swi), 32'(exp_sw.pop_front()));
        check("force_swi_width", 32'(prev_force), 32'd0);
      end
      prev_force = force_swi;
      if (com_pop) begin
        last_pop = cyc;
        pop_cyc.push_back(cyc);
      end
    end else begin
      prev_force = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    fifo.push_back(b);
  endtask

  task automatic send5(input logic [7:0] b0, b1, b2, b3, b4);
    @(negedge clk);
    send_byte(b0); send_byte(b1); send_byte(b2); send_byte(b3); send_byte(b4);
  endtask

  task automatic expect_fwd(input logic [7:0] b0, b1, b2, b3, b4);
    push_exp_t e;
    e.data = b0; e.first = 1'b1; exp_push.push_back(e);
    e.first = 1'b0;
    e.data = b1; exp_push.push_back(e);
    e.data = b2; exp_push.push_back(e);
    e.data = b3; exp_push.push_back(e);
    e.data = b4; exp_push.push_back(e);
  endtask

  // Wait for the FIFO to drain, then let the frame finish executing.
  task automatic drain(input string name);
    int n = 0;
    while (fifo.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (fifo.size() != 0) check({name, "_drain_timeout"}, 32'(fifo.size()), 32'd0);
    repeat (12) @(negedge clk);
  endtask

  initial begin
    int p0;
    int n;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_com_pop", 32'(com_pop), 32'd0);
    check("reset_force_swi", 32'(force_swi), 32'd0);
    check("reset_com_swi", 32'(com_swi), 32'd0);
    check("reset_error", 32'(error), 32'd0);
    check("reset_push", 32'(tf_push_cpuAB), 32'd0);
    check("reset_tdr", 32'(tdr_cpuAB), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // T1: switch to A
    p0 = pop_cyc.size();
    exp_sw.push_back(1'b0);
    send5(8'hEB, 8'h90, 8'h5A, 8'h00, 8'h5A);
    drain("t1");
    check("t1_pop_count", 32'(pop_cyc.size() - p0), 32'd5);
    if (pop_cyc.size() - p0 == 5) begin
      for (int i = p0 + 1; i < p0 + 5; i++)
        check("t1_pop_spacing", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd2);
    end
    check("t1_com_swi", 32'(com_swi), 32'd0);
    check("t1_error", 32'(error), 32'd0);

    // T2: switch to B, then a bad-checksum frame
    exp_sw.push_back(1'b1);
    send5(8'hEB, 8'h90, 8'hA5, 8'h01, 8'hA6);
    drain("t2a");
    check("t2a_com_swi", 32'(com_swi), 32'd1);
    check("t2a_error", 32'(error), 32'd0);
    send5(8'hEB, 8'h90, 8'hA5, 8'h01, 8'h00);
    drain("t2b");
    check("t2b_error", 32'(error), 32'd1);
    check("t2b_com_swi", 32'(com_swi), 32'd1);

    // T3: forwarded frame with wrapping checksum
    expect_fwd(8'hEB, 8'h90, 8'h33, 8'hF0, 8'h23);
    send5(8'hEB, 8'h90, 8'h33, 8'hF0, 8'h23);
    drain("t3");
    check("t3_pushes_left", 32'(exp_push.size()), 32'd0);
    check("t3_error", 32'(error), 32'd0);
    check("t3_com_swi", 32'(com_swi), 32'd1);

    // T4: junk byte and repeated SYNC1 before a switch-to-A frame
    exp_sw.push_back(1'b0);
    @(negedge clk);
    send_byte(8'h12); send_byte(8'hEB);
    send5(8'hEB, 8'h90, 8'h5A, 8'h00, 8'h5A);
    drain("t4");
    check("t4_com_swi", 32'(com_swi), 32'd0);
    check("t4_sw_left", 32'(exp_sw.size()), 32'd0);

    // T5: timeout aborts a partial frame
    @(negedge clk);
    send_byte(8'hEB); send_byte(8'h90); send_byte(8'h33);
    drain("t5a");
    command_time_out_d = 1'b1;
    @(negedge clk);
    command_time_out_d = 1'b0;
    @(negedge clk);
    send_byte(8'hF0); send_byte(8'h23);
    drain("t5b");
    check("t5_error", 32'(error), 32'd0);
    check("t5_pushes_left", 32'(exp_push.size()), 32'd0);

    // T6: reset during the third forwarded push
    exp_push.push_back('{data: 8'hEB, first: 1'b1});
    exp_push.push_back('{data: 8'h90, first: 1'b0});
    send5(8'hEB, 8'h90, 8'h33, 8'hF0, 8'h23);
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (exp_push.size() != 0 && n < 400);
    check("t6_two_pushes_seen", 32'(exp_push.size()), 32'd0);
    @(posedge clk); #1;
    check("t6_third_push", 32'(tf_push_cpuAB), 32'd1);
    check("t6_third_data", 32'(tdr_cpuAB), 32'h33);
    rst_n = 1'b0;
    #1;
    check("t6_rst_push", 32'(tf_push_cpuAB), 32'd0);
    check("t6_rst_tdr", 32'(tdr_cpuAB), 32'd0);
    check("t6_rst_com_swi", 32'(com_swi), 32'd0);
    check("t6_rst_error", 32'(error), 32'd0);
    check("t6_rst_force_swi", 32'(force_swi), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_no_push_after", 32'(tf_push_cpuAB), 32'd0);
    exp_sw.push_back(1'b1);
    send5(8'hEB, 8'h90, 8'hA5, 8'h01, 8'hA6);
    drain("t6b");
    check("t6b_com_swi", 32'(com_swi), 32'd1);
    check("t6b_error", 32'(error), 32'd0);
    check("t6b_sw_left", 32'(exp_sw.size()), 32'd0);
    check("t6b_pushes_left", 32'(exp_push.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
